// File: rtl/conv_window_sched_if.sv
// Memory-read and FIFO-push bus between the window scheduler and its memories/FIFO.
interface conv_window_sched_if #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PA_W         = 10,
  parameter int WA_W         = 4
);
  logic                                mem_rd;
  logic [PA_W-1:0]                     pixel_addr;
  logic [WA_W-1:0]                     weight_addr;
  logic [PIXEL_WIDTH-1:0]              pixel_rdata;
  logic [WEIGHT_WIDTH-1:0]             weight_rdata;
  logic                                fifo_afull;
  logic                                fifo_write;
  logic [PIXEL_WIDTH+WEIGHT_WIDTH-1:0] fifo_wdata;

  modport master (
    output mem_rd, pixel_addr, weight_addr, fifo_write, fifo_wdata,
    input  pixel_rdata, weight_rdata, fifo_afull
  );

  modport slave (
    input  mem_rd, pixel_addr, weight_addr, fifo_write, fifo_wdata,
    output pixel_rdata, weight_rdata, fifo_afull
  );
endinterface

// File: rtl/conv_window_sched.sv
// Issues pixel/weight reads for every KxK convolution window in raster order and
// forwards the returned pair into a downstream FIFO, throttled by fifo_afull.
module conv_window_sched #(
  parameter int IMG_W        = 32,
  parameter int IMG_H        = 32,
  parameter int K            = 3,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [9:0]           win_cnt,
  conv_window_sched_if.master  bus
);

  localparam int PA_W = $clog2(IMG_W*IMG_H);
  localparam int WA_W = $clog2(K*K);
  localparam int RW   = $clog2(IMG_H+1);
  localparam int CW   = $clog2(IMG_W+1);
  localparam int KW   = $clog2(K+1);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-K);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-K);
  localparam logic [KW-1:0] K_LAST   = KW'(K-1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [KW-1:0]   kr_q, kc_q;
  logic            rd_p0;
  logic            vld_p1;
  logic            start_acc;
  logic            kc_last, kr_last, col_last, row_last, win_last, pass_last;

  assign kc_last   = (kc_q == K_LAST);
  assign kr_last   = (kr_q == K_LAST);
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign win_last  = kc_last && kr_last;
  assign pass_last = win_last && col_last && row_last;
  assign start_acc = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    rd_p0   = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        rd_p0 = !bus.fifo_afull;
        if (rd_p0 && pass_last) state_d = DRAIN;
      end
      // No reads are issued here, so the only outstanding one is written this cycle.
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vld_p1  <= 1'b0;
      win_cnt <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= rd_p0;
      if (start_acc)
        win_cnt <= '0;
      else if (rd_p0 && win_last)
        win_cnt <= win_cnt + 10'd1;
    end
  end

  // Stage p0: scan counters; they wrap to zero after the final read of a pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      kr_q  <= '0;
      kc_q  <= '0;
    end else if (rd_p0) begin
      if (kc_last) begin
        kc_q <= '0;
        if (kr_last) begin
          kr_q <= '0;
          if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end else begin
          kr_q <= kr_q + KW'(1);
        end
      end else begin
        kc_q <= kc_q + KW'(1);
      end
    end
  end

  assign bus.mem_rd      = rd_p0;
  assign bus.pixel_addr  = PA_W'((32'(row_q) + 32'(kr_q)) * IMG_W + 32'(col_q) + 32'(kc_q));
  assign bus.weight_addr = WA_W'(32'(kr_q) * K + 32'(kc_q));

  // Stage p1: memory data returns one cycle after the read strobe.
  assign bus.fifo_write  = vld_p1;
  assign bus.fifo_wdata  = vld_p1 ? {bus.pixel_rdata, bus.weight_rdata} : '0;

  assign busy = (state_q == FETCH) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched with an address model and a wdata scoreboard.
module tb_conv_window_sched;
  localparam int W     = 32;
  localparam int H     = 32;
  localparam int KK    = 3;
  localparam int NWC   = W - KK + 1;
  localparam int NREAD = KK * KK * NWC * (H - KK + 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [9:0] win_cnt;

  conv_window_sched_if #(.PIXEL_WIDTH(8), .WEIGHT_WIDTH(8), .PA_W(10), .WA_W(4)) bus ();

  conv_window_sched #(.IMG_W(W), .IMG_H(H), .K(KK), .PIXEL_WIDTH(8), .WEIGHT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .win_cnt(win_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.pixel_rdata  <= bus.pixel_addr[7:0];
      bus.weight_rdata <= 8'hA0 + 8'(bus.weight_addr);
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          rd_idx, rd_cnt, wr_cnt, done_cnt, first_rd, last_rd, done_at, t0;
  logic [31:0] last_pa, last_wa, m_pa, m_wa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pa(input int n);
    int w, t;
    w = n / (KK * KK);
    t = n % (KK * KK);
    return 32'(((w / NWC) + t / KK) * W + (w % NWC) + t % KK);
  endfunction

  function automatic logic [31:0] exp_wa(input int n);
    return 32'(n % (KK * KK));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fifo_write) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(exp_q.pop_front()));
      end
      if (bus.fifo_afull) chk("rd_while_afull", 32'(bus.mem_rd), 0);
      if (bus.mem_rd) begin
        m_pa = exp_pa(rd_idx);
        m_wa = exp_wa(rd_idx);
        if (rd_cnt == 0) first_rd = cyc - t0;
        chk("pixel_addr", 32'(bus.pixel_addr), m_pa);
        chk("weight_addr", 32'(bus.weight_addr), m_wa);
        exp_q.push_back({m_pa[7:0], 8'hA0 + m_wa[7:0]});
        last_rd = cyc - t0;
        last_pa = 32'(bus.pixel_addr);
        last_wa = 32'(bus.weight_addr);
        rd_cnt++;
        rd_idx++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc - t0;
      end
    end
  end

  task automatic new_pass();
    rd_idx = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    first_rd = -1; last_rd = -1; done_at = -1;
    exp_q.delete();
  endtask

  task automatic start_pass();
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    @(negedge clk);
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_rd_cnt"}, rd_cnt, NREAD);
    chk({tag, "_wr_cnt"}, wr_cnt, NREAD);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_win_cnt"}, 32'(win_cnt), 900);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    bus.fifo_afull = 1'b0;
    new_pass();
    t0 = 0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_fifo_write", 32'(bus.fifo_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pixel_addr", 32'(bus.pixel_addr), 0);
    chk("rst_weight_addr", 32'(bus.weight_addr), 0);
    chk("rst_win_cnt", 32'(win_cnt), 0);
    chk("rst_fifo_wdata", 32'(bus.fifo_wdata), 0);
    reset = 1'b0;

    // Full pass without back-pressure
    new_pass();
    start_pass();
    wait_done(NREAD + 100);
    @(negedge clk);
    chk("p1_first_rd_cycle", first_rd, 1);
    chk("p1_last_rd_cycle", last_rd, NREAD);
    chk("p1_done_cycle", done_at, NREAD + 2);
    chk("p1_last_pa", last_pa, 1023);
    chk("p1_last_wa", last_wa, 8);
    chk("p1_done_after", 32'(done), 0);
    check_pass("p1");

    // Back-pressure for 10 cycles right after read 4 of window 0
    new_pass();
    start_pass();
    n = 0;
    @(negedge clk);
    while (!(bus.mem_rd && bus.weight_addr == 4'd4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_read4_seen", 32'(bus.mem_rd && bus.weight_addr == 4'd4), 1);
    @(posedge clk);
    #1 bus.fifo_afull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("stall_read4_written", 32'(bus.fifo_write), 1);
      chk("stall_mem_rd", 32'(bus.mem_rd), 0);
    end
    @(posedge clk);
    #1 bus.fifo_afull = 1'b0;
    @(negedge clk);
    chk("resume_mem_rd", 32'(bus.mem_rd), 1);
    chk("resume_pa", 32'(bus.pixel_addr), 34);
    chk("resume_wa", 32'(bus.weight_addr), 5);
    wait_done(NREAD + 100);
    @(negedge clk);
    check_pass("p2");

    // Start pulses mid-pass and during DONE are ignored
    new_pass();
    start_pass();
    while (cyc - t0 < 50) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(NREAD + 100);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ign_busy", 32'(busy), 0);
      chk("ign_mem_rd", 32'(bus.mem_rd), 0);
    end
    chk("p3_done_cycle", done_at, NREAD + 2);
    check_pass("p3");

    // Reset in the middle of a pass, then restart
    new_pass();
    start_pass();
    n = 0;
    @(negedge clk);
    while (win_cnt != 10'd100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_win100_seen", 32'(win_cnt), 100);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    new_pass();
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_fifo_write", 32'(bus.fifo_write), 0);
    chk("mid_win_cnt", 32'(win_cnt), 0);
    chk("mid_pixel_addr", 32'(bus.pixel_addr), 0);
    chk("mid_weight_addr", 32'(bus.weight_addr), 0);
    start_pass();
    wait_done(NREAD + 100);
    @(negedge clk);
    chk("p4_first_rd_cycle", first_rd, 1);
    check_pass("p4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_window_sched.md
CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

Interface
REQ-001 The block SHALL have parameter IMG_W, default 32, meaning input image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 32, meaning input image height in pixels.
REQ-003 The block SHALL have parameter K, default 3, meaning square kernel size.
REQ-004 The block SHALL have parameter PIXEL_WIDTH, default 8, meaning pixel word width.
REQ-005 The block SHALL have parameter WEIGHT_WIDTH, default 8, meaning weight word width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle request to begin one full convolution pass.
REQ-009 The block SHALL have port fifo_afull, input, 1 bit: downstream pixel/weight FIFO has at most 1 free entry.
REQ-010 The block SHALL have port pixel_rdata, input, PIXEL_WIDTH bits: image memory read data, valid 1 cycle after mem_rd.
REQ-011 The block SHALL have port weight_rdata, input, WEIGHT_WIDTH bits: weight memory read data, valid 1 cycle after mem_rd.
REQ-012 The block SHALL have port mem_rd, output, 1 bit: read strobe shared by the image and weight memories.
REQ-013 The block SHALL have port pixel_addr, output, clog2(IMG_W*IMG_H) bits (10 at defaults): image memory address.
REQ-014 The block SHALL have port weight_addr, output, clog2(K*K) bits (4 at defaults): weight memory address.
REQ-015 The block SHALL have port fifo_write, output, 1 bit: push strobe into the downstream FIFO.
REQ-016 The block SHALL have port fifo_wdata, output, PIXEL_WIDTH+WEIGHT_WIDTH bits: {pixel_rdata, weight_rdata}.
REQ-017 The block SHALL have port busy, output, 1 bit: a pass is in progress.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a pass.
REQ-019 The block SHALL have port win_cnt, output, 10 bits: number of windows whose 9 reads have all been issued.

Function
REQ-020 FSM SHALL have states IDLE, FETCH, DRAIN, DONE; transitions: IDLE->FETCH on start; FETCH->DRAIN after last read issued; DRAIN->DONE when no read is in flight; DONE->IDLE unconditionally.
REQ-021 Window origin (row, col) SHALL scan raster order 0..IMG_H-K by 0..IMG_W-K (900 windows at defaults), col fastest.
REQ-022 Within a window, (kr, kc) SHALL scan 0..K-1 each, kc fastest; pixel_addr = (row+kr)*IMG_W + col+kc; weight_addr = kr*K + kc.
REQ-023 In FETCH, mem_rd SHALL be 1 in exactly those cycles where fifo_afull=0; addresses SHALL advance only on cycles with mem_rd=1.
REQ-024 fifo_write SHALL equal mem_rd delayed 1 cycle, with fifo_wdata = {pixel_rdata, weight_rdata} in the same cycle.
REQ-025 No address tuple SHALL be skipped or repeated; K*K*900 = 8100 reads and 8100 writes per pass at defaults.
REQ-026 win_cnt SHALL increment on the read with kr=kc=K-1 and SHALL clear on start accepted in IDLE.
REQ-027 busy SHALL be 1 in FETCH and DRAIN, and 0 in IDLE and DONE.
REQ-028 done SHALL be 1 only in DONE, one cycle after the final fifo_write.
REQ-029 start SHALL be ignored in every state other than IDLE.
REQ-030 A start in the same cycle as DONE SHALL be ignored.
REQ-031 fifo_afull SHALL not affect DRAIN; an in-flight read SHALL always be written.
REQ-032 pixel_addr and weight_addr SHALL hold their value whenever mem_rd=0.

Reset
REQ-033 With reset=1 at a clock edge, the block SHALL enter IDLE.
REQ-034 With reset=1 at a clock edge, mem_rd, fifo_write, busy, done SHALL be 0.
REQ-035 With reset=1 at a clock edge, pixel_addr, weight_addr, win_cnt, fifo_wdata SHALL be 0.
REQ-036 With reset=1 at a clock edge, all scan counters SHALL be 0.
REQ-037 Reset mid-pass SHALL drop any in-flight read, so no fifo_write occurs in the following cycle.

Verification
REQ-038 Reset held 2 cycles -> all outputs 0, state IDLE.
REQ-039 start at cycle 0, fifo_afull=0 throughout -> mem_rd cycles 1..8100, pixel_addr sequence 0,1,2,32,33,34,64,65,66,1,...; last read addr 1023/weight 8; done=1 at cycle 8102 only; win_cnt=900.
REQ-040 fifo_afull=1 for 10 cycles after read 4 of window 0 -> mem_rd=0 those 10 cycles; read 4 still written; resumes at pixel_addr 34, weight_addr 5; total writes 8100.
REQ-041 start pulses at cycle 50 and in the DONE cycle -> both ignored; single pass, single done pulse.
REQ-042 reset asserted when win_cnt=100 -> next cycle busy=0, fifo_write=0; subsequent start restarts at pixel_addr 0, weight_addr 0, win_cnt 0.
REQ-043 pixel memory model returning addr[7:0], weight returning 8'hA0+addr -> every fifo_wdata equals {addr[7:0], 8'hA0+weight_addr} of the read issued one cycle earlier.
